trap_ctrl: RTL and testbench
============================

# trap_ctrl

Trap sequencer for the pipelined RV64 core. Arbitrates exception packets (`ExceptStruct::ExceptPack`) from the decode-stage instruction examiner and the memory stage, plus `mret`/`sret` commits. Sequences trap entry and return through the single CSR write port, holding the pipeline stalled and flushed until the PC redirect is issued. Also owns the current privilege register.

## Interface
Parameters:
- `XLEN`, 64, data/PC width.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `except_id_i`  in  ExceptPack  decode-stage exception (`except`, `epc`, `ecause`, `etval`).
- `except_mem_i`  in  ExceptPack  memory-stage exception (older instruction).
- `mret_i`, `sret_i`  in  1  committing xRET instruction, one-cycle pulse.
- `mstatus_i`  in  64  current mstatus.
- `medeleg_i`  in  64  exception delegation mask.
- `mtvec_i`, `stvec_i`, `mepc_i`, `sepc_i`  in  64  CSR read values.
- `csr_we_o`  out  1  CSR write enable.
- `csr_waddr_o`  out  12  CSR write address.
- `csr_wdata_o`  out  64  CSR write data.
- `stall_o`, `flush_o`  out  1  pipeline hold / squash.
- `redirect_valid_o`  out  1  one-cycle PC redirect strobe.
- `redirect_pc_o`  out  64  redirect target.
- `priv_o`  out  2  current privilege (U=0, S=1, M=3).

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, RET_STATUS, REDIR.
- IDLE accept priority: `except_mem_i.except` > `except_id_i.except` > `mret_i` > `sret_i`.
  - The winner is latched (epc, cause, tval, kind).
  - Losers are dropped; the flush re-executes them.
- Exception path: IDLE → W_EPC → W_CAUSE → W_TVAL → W_STATUS → REDIR → IDLE.
- xRET path: IDLE → RET_STATUS → REDIR → IDLE.
- Delegation is decided at accept: target = S if `priv_o`≤1 and `medeleg_i[cause[5:0]]`, otherwise M.
- M target:
  - Writes: 0x341 ← epc, 0x342 ← cause, 0x343 ← tval, 0x300 ← mstatus with MPP=priv, MPIE=MIE, MIE=0.
  - REDIR: `redirect_pc_o` = `mtvec_i & ~3`, then `priv_o`←3.
- S target:
  - Writes: 0x141, 0x142, 0x143, and 0x300 with SPP=priv[0], SPIE=SIE, SIE=0.
  - REDIR: `redirect_pc_o` = `stvec_i & ~3`, then `priv_o`←1.
- mret:
  - RET_STATUS writes 0x300 with MIE=MPIE, MPIE=1, MPP=0.
  - REDIR: pc=`mepc_i`, `priv_o`←old MPP.
- sret:
  - RET_STATUS writes 0x300 with SIE=SPIE, SPIE=1, SPP=0.
  - REDIR: pc=`sepc_i`, `priv_o`←{0,old SPP}.
- W_STATUS and RET_STATUS compute from live `mstatus_i`. Earlier writes never touch 0x300, so no hazard.
- Only direct tvec mode is supported; the mode bits are masked.

## Timing
- Reset (rstn=0 at an edge): state=IDLE, `priv_o`=3, `csr_we_o`=0, `csr_waddr_o`=0, `csr_wdata_o`=0, `stall_o`=0, `flush_o`=0, `redirect_valid_o`=0, `redirect_pc_o`=0, latches cleared.
- Reset mid-sequence abandons the trap; no further CSR writes occur.
- All outputs are registered, driven from the current state.
- Exception accepted at edge t:
  - `csr_we_o` high in cycles t+1..t+4, one CSR per cycle, in the listed order.
  - `redirect_valid_o` high only in t+5; `priv_o` updates at edge t+6.
- xRET accepted at t: write in t+1, redirect in t+2.
- `stall_o` and `flush_o` are high in every non-IDLE cycle, including REDIR.
- Inputs arriving in non-IDLE states are ignored.
- A new event is accepted in the first IDLE cycle after REDIR. Back-to-back traps are therefore spaced ≥6 cycles apart.
- An exception and an xRET in the same cycle: the exception wins and the xRET is discarded.

## Structure
- Shared package `TrapPkg`:
  - state enum;
  - CSR address constants (MSTATUS, MEPC, MCAUSE, MTVAL, SEPC, SCAUSE, STVAL);
  - mstatus bit positions (SIE=1, MIE=3, SPIE=5, MPIE=7, SPP=8, MPP=12:11);
  - privilege encodings.
- Cause codes remain in `Define.vh`.
- One sub-module, `trap_target_sel`: combinational delegation decision, target tvec, and the new-mstatus computation for trap entry and return.

## Test plan
- U-mode ecall on `except_id_i` (cause 8, epc 0x1000), medeleg=0, mtvec=0x8000_0001 → writes 0x341=0x1000, 0x342=8, 0x343=0, 0x300 with MPP=0 and MIE=0 in cycles t+1..t+4; redirect 0x8000_0000 at t+5; `priv_o`=3.
- Same ecall with medeleg[8]=1, stvec=0x9000 → writes to 0x141/0x142/0x143, SPP=0; redirect 0x9000; `priv_o`=1.
- Same-cycle illegal-instruction exceptions on `except_id_i` and `except_mem_i` (epc 0x2004 vs 0x2000) → only the mem packet is processed (epc 0x2000 written).
- mret with mstatus MPP=1, MPIE=1, mepc=0x3000 → 0x300 written with MIE=1, MPP=0; redirect 0x3000 at t+2; `priv_o`=1.
- rstn low during W_CAUSE → no writes after reset; all outputs at reset values; `priv_o`=3.
- Exception arriving during a running trap → ignored; `csr_we_o` count for that trap stays exactly 4.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer.
// Contents:
//   - exception packet type (valid flag, epc, cause, tval);
//   - sequencer state and event-kind enums;
//   - CSR write addresses and mstatus field positions;
//   - privilege encodings.
package trap_ctrl_pkg;

  localparam int XLEN_W = 64;

  typedef struct packed {
    logic              except;
    logic [XLEN_W-1:0] epc;
    logic [XLEN_W-1:0] ecause;
    logic [XLEN_W-1:0] etval;
  } except_pack_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_W_EPC      = 3'd1,
    ST_W_CAUSE    = 3'd2,
    ST_W_TVAL     = 3'd3,
    ST_W_STATUS   = 3'd4,
    ST_RET_STATUS = 3'd5,
    ST_REDIR      = 3'd6
  } trap_state_e;

  typedef enum logic [1:0] {
    KIND_EXC  = 2'd0,
    KIND_MRET = 2'd1,
    KIND_SRET = 2'd2
  } trap_kind_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;

  localparam int MS_SIE    = 1;
  localparam int MS_MIE    = 3;
  localparam int MS_SPIE   = 5;
  localparam int MS_MPIE   = 7;
  localparam int MS_SPP    = 8;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

endpackage

// File: rtl/trap_ctrl_target_sel.sv
// trap_target_sel: purely combinational helper for the trap sequencer.
// Ports:
//   priv_i          current privilege
//   cause_i         low six cause bits of the candidate exception
//   medeleg_i       exception delegation mask
//   tgt_s_i         latched target (1 = supervisor) of the trap in flight
//   mstatus_i       live mstatus
//   mtvec_i/stvec_i trap vector CSRs
//   deleg_s_o       candidate exception would be taken in S-mode
//   tvec_o          handler address for the latched target (direct mode)
//   entry_status_o  mstatus value to write on trap entry
//   mret_status_o   mstatus value to write on mret
//   sret_status_o   mstatus value to write on sret
//   ret_priv_m_o    privilege restored by mret (MPP)
//   ret_priv_s_o    privilege restored by sret ({0,SPP})
module trap_target_sel
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      priv_i,
  input  logic [5:0]      cause_i,
  input  logic [XLEN-1:0] medeleg_i,
  input  logic            tgt_s_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] stvec_i,
  output logic            deleg_s_o,
  output logic [XLEN-1:0] tvec_o,
  output logic [XLEN-1:0] entry_status_o,
  output logic [XLEN-1:0] mret_status_o,
  output logic [XLEN-1:0] sret_status_o,
  output logic [1:0]      ret_priv_m_o,
  output logic [1:0]      ret_priv_s_o
);

  always_comb begin
    // M-mode traps are never delegated down.
    deleg_s_o = (priv_i <= PRIV_S) && medeleg_i[cause_i];

    // Only direct mode: mode field forced to zero.
    tvec_o = tgt_s_i ? {stvec_i[XLEN-1:2], 2'b00} : {mtvec_i[XLEN-1:2], 2'b00};

    entry_status_o = mstatus_i;
    if (tgt_s_i) begin
      entry_status_o[MS_SPP]  = priv_i[0];
      entry_status_o[MS_SPIE] = mstatus_i[MS_SIE];
      entry_status_o[MS_SIE]  = 1'b0;
    end else begin
      entry_status_o[MS_MPP_HI:MS_MPP_LO] = priv_i;
      entry_status_o[MS_MPIE]             = mstatus_i[MS_MIE];
      entry_status_o[MS_MIE]              = 1'b0;
    end

    mret_status_o                      = mstatus_i;
    mret_status_o[MS_MIE]              = mstatus_i[MS_MPIE];
    mret_status_o[MS_MPIE]             = 1'b1;
    mret_status_o[MS_MPP_HI:MS_MPP_LO] = PRIV_U;

    sret_status_o          = mstatus_i;
    sret_status_o[MS_SIE]  = mstatus_i[MS_SPIE];
    sret_status_o[MS_SPIE] = 1'b1;
    sret_status_o[MS_SPP]  = 1'b0;

    ret_priv_m_o = mstatus_i[MS_MPP_HI:MS_MPP_LO];
    ret_priv_s_o = {1'b0, mstatus_i[MS_SPP]};
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap entry / xRET sequencer and privilege owner.
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   except_id_i/except_mem_i  exception packets (mem stage wins)
//   mret_i, sret_i            committing xRET pulses
//   mstatus_i, medeleg_i      live CSR values
//   mtvec_i, stvec_i,
//   mepc_i, sepc_i            CSR read values for redirect targets
//   csr_we_o/waddr_o/wdata_o  single CSR write port
//   stall_o, flush_o          high in every non-idle cycle
//   redirect_valid_o/pc_o     one-cycle PC redirect
//   priv_o                    current privilege
// All outputs are flops loaded from the next state, so they line up with
// the state they describe.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  except_pack_t    except_id_i,
  input  except_pack_t    except_mem_i,
  input  logic            mret_i,
  input  logic            sret_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] medeleg_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] stvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] sepc_i,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            stall_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [1:0]      priv_o
);

  trap_state_e     state_q, state_d;
  trap_kind_e      kind_q, kind_d;
  logic            tgt_s_q, tgt_s_d;
  logic [XLEN-1:0] epc_q, epc_d, cause_q, cause_d, tval_q, tval_d;
  logic [1:0]      ret_priv_q, ret_priv_d, priv_q, priv_d;
  logic            we_q, we_d, busy_q, busy_d, redir_v_q, redir_v_d;
  logic [11:0]     waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d, redir_pc_q, redir_pc_d;

  except_pack_t    sel_pkt;
  logic            deleg_s;
  logic [XLEN-1:0] tvec, entry_status, mret_status, sret_status;
  logic [1:0]      ret_priv_m, ret_priv_s;

  // Older (mem-stage) instruction has priority; its valid bit doubles as
  // "any exception present".
  assign sel_pkt = except_mem_i.except ? except_mem_i : except_id_i;

  trap_target_sel #(.XLEN(XLEN)) u_sel (
    .priv_i         (priv_q),
    .cause_i        (sel_pkt.ecause[5:0]),
    .medeleg_i      (medeleg_i),
    .tgt_s_i        (tgt_s_q),
    .mstatus_i      (mstatus_i),
    .mtvec_i        (mtvec_i),
    .stvec_i        (stvec_i),
    .deleg_s_o      (deleg_s),
    .tvec_o         (tvec),
    .entry_status_o (entry_status),
    .mret_status_o  (mret_status),
    .sret_status_o  (sret_status),
    .ret_priv_m_o   (ret_priv_m),
    .ret_priv_s_o   (ret_priv_s)
  );

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    tgt_s_d    = tgt_s_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    tval_d     = tval_q;
    ret_priv_d = ret_priv_q;
    priv_d     = priv_q;

    unique case (state_q)
      ST_IDLE: begin
        if (sel_pkt.except) begin
          state_d = ST_W_EPC;
          kind_d  = KIND_EXC;
          tgt_s_d = deleg_s;
          epc_d   = sel_pkt.epc;
          cause_d = sel_pkt.ecause;
          tval_d  = sel_pkt.etval;
        end else if (mret_i) begin
          state_d    = ST_RET_STATUS;
          kind_d     = KIND_MRET;
          ret_priv_d = ret_priv_m;
        end else if (sret_i) begin
          state_d    = ST_RET_STATUS;
          kind_d     = KIND_SRET;
          ret_priv_d = ret_priv_s;
        end
      end
      ST_W_EPC:      state_d = ST_W_CAUSE;
      ST_W_CAUSE:    state_d = ST_W_TVAL;
      ST_W_TVAL:     state_d = ST_W_STATUS;
      ST_W_STATUS:   state_d = ST_REDIR;
      ST_RET_STATUS: state_d = ST_REDIR;
      ST_REDIR: begin
        state_d = ST_IDLE;
        if (kind_q == KIND_EXC) priv_d = tgt_s_q ? PRIV_S : PRIV_M;
        else                    priv_d = ret_priv_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // Output image of the state being entered.
    we_d       = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;
    redir_v_d  = 1'b0;
    redir_pc_d = '0;
    busy_d     = (state_d != ST_IDLE);

    unique case (state_d)
      ST_W_EPC: begin
        we_d    = 1'b1;
        waddr_d = tgt_s_d ? CSR_SEPC : CSR_MEPC;
        wdata_d = epc_d;
      end
      ST_W_CAUSE: begin
        we_d    = 1'b1;
        waddr_d = tgt_s_d ? CSR_SCAUSE : CSR_MCAUSE;
        wdata_d = cause_d;
      end
      ST_W_TVAL: begin
        we_d    = 1'b1;
        waddr_d = tgt_s_d ? CSR_STVAL : CSR_MTVAL;
        wdata_d = tval_d;
      end
      ST_W_STATUS: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        wdata_d = entry_status;
      end
      ST_RET_STATUS: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        wdata_d = (kind_d == KIND_MRET) ? mret_status : sret_status;
      end
      ST_REDIR: begin
        redir_v_d = 1'b1;
        unique case (kind_d)
          KIND_EXC:  redir_pc_d = tvec;
          KIND_MRET: redir_pc_d = mepc_i;
          default:   redir_pc_d = sepc_i;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      kind_q     <= KIND_EXC;
      tgt_s_q    <= 1'b0;
      epc_q      <= '0;
      cause_q    <= '0;
      tval_q     <= '0;
      ret_priv_q <= PRIV_U;
      priv_q     <= PRIV_M;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      redir_v_q  <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      tgt_s_q    <= tgt_s_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      tval_q     <= tval_d;
      ret_priv_q <= ret_priv_d;
      priv_q     <= priv_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      redir_v_q  <= redir_v_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign csr_we_o         = we_q;
  assign csr_waddr_o      = waddr_q;
  assign csr_wdata_o      = wdata_q;
  assign stall_o          = busy_q;
  assign flush_o          = busy_q;
  assign redirect_valid_o = redir_v_q;
  assign redirect_pc_o    = redir_pc_q;
  assign priv_o           = priv_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Testbench for trap_ctrl: directed vector table, reset-abort sequence and
// randomized events checked against a behavioural model.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rstn;
  except_pack_t except_id_i, except_mem_i;
  logic         mret_i, sret_i;
  logic [63:0]  mstatus_i, medeleg_i, mtvec_i, stvec_i, mepc_i, sepc_i;
  logic         csr_we_o, stall_o, flush_o, redirect_valid_o;
  logic [11:0]  csr_waddr_o;
  logic [63:0]  csr_wdata_o, redirect_pc_o;
  logic [1:0]   priv_o;

  int total = 0;
  int bad   = 0;
  logic [1:0] cur_priv;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rstn(rstn), .except_id_i(except_id_i), .except_mem_i(except_mem_i),
    .mret_i(mret_i), .sret_i(sret_i), .mstatus_i(mstatus_i), .medeleg_i(medeleg_i),
    .mtvec_i(mtvec_i), .stvec_i(stvec_i), .mepc_i(mepc_i), .sepc_i(sepc_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .priv_o(priv_o)
  );

  typedef struct {
    logic        mem_v, id_v, mret, sret;
    logic [63:0] mem_epc, mem_cause, mem_tval, id_epc, id_cause, id_tval;
    logic [63:0] mstatus, medeleg, mtvec, stvec, mepc, sepc;
    int          nwr;
    logic [3:0][11:0] addr;
    logic [3:0][63:0] data;
    logic [63:0] pc;
    logic [1:0]  priv;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    v.mtvec = 64'h8000_0001;
    v.stvec = 64'h9001;
    return v;
  endfunction

  // Expected behaviour derived directly from the trap rules.
  function automatic vec_t model(input vec_t v, input logic [1:0] p);
    vec_t r;
    logic [63:0] s, cause, tvec;
    logic sdel;
    r = v;
    s = v.mstatus;
    if (v.mem_v || v.id_v) begin
      cause = v.mem_v ? v.mem_cause : v.id_cause;
      sdel = (p == 2'd0 || p == 2'd1) && (((v.medeleg >> (cause % 64)) % 2) == 1);
      r.nwr = 4;
      r.addr[0] = sdel ? 12'h141 : 12'h341;
      r.addr[1] = sdel ? 12'h142 : 12'h342;
      r.addr[2] = sdel ? 12'h143 : 12'h343;
      r.addr[3] = 12'h300;
      r.data[0] = v.mem_v ? v.mem_epc : v.id_epc;
      r.data[1] = cause;
      r.data[2] = v.mem_v ? v.mem_tval : v.id_tval;
      if (sdel)
        r.data[3] = (s & ~64'h122) + (((s >> 1) % 2) * 64'h20) + ((p % 2) * 64'h100);
      else
        r.data[3] = (s & ~64'h1888) + (((s >> 3) % 2) * 64'h80) + (64'(p) * 64'h800);
      tvec = sdel ? v.stvec : v.mtvec;
      r.pc = tvec - (tvec % 4);
      r.priv = sdel ? 2'd1 : 2'd3;
    end else begin
      r.nwr = 1;
      r.addr[0] = 12'h300;
      if (v.mret) begin
        r.data[0] = (s & ~64'h1888) + (((s >> 7) % 2) * 64'h8) + 64'h80;
        r.pc = v.mepc;
        r.priv = 2'((s >> 11) % 4);
      end else begin
        r.data[0] = (s & ~64'h122) + (((s >> 5) % 2) * 64'h2) + 64'h20;
        r.pc = v.sepc;
        r.priv = 2'((s >> 8) % 2);
      end
    end
    return r;
  endfunction

  task automatic clear_events();
    except_id_i.except = 1'b0;
    except_mem_i.except = 1'b0;
    mret_i = 1'b0;
    sret_i = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    except_mem_i = '{except: v.mem_v, epc: v.mem_epc, ecause: v.mem_cause, etval: v.mem_tval};
    except_id_i  = '{except: v.id_v,  epc: v.id_epc,  ecause: v.id_cause,  etval: v.id_tval};
    mret_i = v.mret; sret_i = v.sret;
    mstatus_i = v.mstatus; medeleg_i = v.medeleg;
    mtvec_i = v.mtvec; stvec_i = v.stvec; mepc_i = v.mepc; sepc_i = v.sepc;
  endtask

  // Accepts one event, then follows it cycle by cycle until idle again.
  task automatic run_vec(input vec_t v, input bit inject);
    int n;
    n = v.nwr;
    @(posedge clk); #1;
    drive(v);
    @(posedge clk); #1;
    clear_events();
    for (int k = 1; k <= n + 4; k++) begin
      @(negedge clk);
      if (k <= n) begin
        chk($sformatf("we[%0d]", k), 64'(csr_we_o), 64'd1);
        chk($sformatf("waddr[%0d]", k), 64'(csr_waddr_o), 64'(v.addr[k-1]));
        chk($sformatf("wdata[%0d]", k), csr_wdata_o, v.data[k-1]);
        chk($sformatf("redir_lo[%0d]", k), 64'(redirect_valid_o), 64'd0);
      end else if (k == n + 1) begin
        chk("we_at_redir", 64'(csr_we_o), 64'd0);
        chk("redir_v", 64'(redirect_valid_o), 64'd1);
        chk("redir_pc", redirect_pc_o, v.pc);
      end else begin
        chk($sformatf("we_idle[%0d]", k), 64'(csr_we_o), 64'd0);
        chk($sformatf("redir_idle[%0d]", k), 64'(redirect_valid_o), 64'd0);
      end
      chk($sformatf("stall[%0d]", k), 64'(stall_o), 64'(k <= n + 1));
      chk($sformatf("flush[%0d]", k), 64'(flush_o), 64'(k <= n + 1));
      if (k == 1) chk("priv_hold", 64'(priv_o), 64'(cur_priv));
      if (k == n + 2) chk("priv_new", 64'(priv_o), 64'(v.priv));
      if (inject && k == 1) begin
        except_id_i.except = 1'b1;
        except_id_i.ecause = 64'd2;
        mret_i = 1'b1;
      end
      if (inject && k == n + 1) clear_events();
    end
    cur_priv = v.priv;
  endtask

  initial begin
    vec_t v;
    rstn = 1'b0;
    except_id_i = '0; except_mem_i = '0;
    mret_i = 0; sret_i = 0;
    mstatus_i = '0; medeleg_i = '0; mtvec_i = '0; stvec_i = '0; mepc_i = '0; sepc_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 64'(csr_we_o), 64'd0);
    chk("rst_waddr", 64'(csr_waddr_o), 64'd0);
    chk("rst_wdata", csr_wdata_o, 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_flush", 64'(flush_o), 64'd0);
    chk("rst_redir_v", 64'(redirect_valid_o), 64'd0);
    chk("rst_redir_pc", redirect_pc_o, 64'd0);
    chk("rst_priv", 64'(priv_o), 64'd3);
    rstn = 1'b1;
    cur_priv = 2'd3;

    // mret to U (MPP=0, MPIE=1)
    tbl[0] = blank(); tbl[0].mret = 1; tbl[0].mstatus = 64'h80; tbl[0].mepc = 64'h500;
    tbl[0].nwr = 1; tbl[0].addr[0] = 12'h300; tbl[0].data[0] = 64'h88; tbl[0].pc = 64'h500; tbl[0].priv = 0;
    // U ecall, not delegated
    tbl[1] = blank(); tbl[1].id_v = 1; tbl[1].id_epc = 64'h1000; tbl[1].id_cause = 8; tbl[1].mstatus = 64'h8;
    tbl[1].nwr = 4; tbl[1].addr = {12'h300, 12'h343, 12'h342, 12'h341};
    tbl[1].data = {64'h80, 64'h0, 64'h8, 64'h1000}; tbl[1].pc = 64'h8000_0000; tbl[1].priv = 3;
    // back to U
    tbl[2] = blank(); tbl[2].mret = 1; tbl[2].mstatus = 64'h8; tbl[2].mepc = 64'h600;
    tbl[2].nwr = 1; tbl[2].addr[0] = 12'h300; tbl[2].data[0] = 64'h80; tbl[2].pc = 64'h600; tbl[2].priv = 0;
    // U ecall delegated to S
    tbl[3] = blank(); tbl[3].id_v = 1; tbl[3].id_epc = 64'h1000; tbl[3].id_cause = 8;
    tbl[3].medeleg = 64'h100; tbl[3].mstatus = 64'h2;
    tbl[3].nwr = 4; tbl[3].addr = {12'h300, 12'h143, 12'h142, 12'h141};
    tbl[3].data = {64'h20, 64'h0, 64'h8, 64'h1000}; tbl[3].pc = 64'h9000; tbl[3].priv = 1;
    // sret with SPP=1, SPIE=1
    tbl[4] = blank(); tbl[4].sret = 1; tbl[4].mstatus = 64'h120; tbl[4].sepc = 64'h700;
    tbl[4].nwr = 1; tbl[4].addr[0] = 12'h300; tbl[4].data[0] = 64'h22; tbl[4].pc = 64'h700; tbl[4].priv = 1;
    // id + mem + mret all at once: mem packet wins
    tbl[5] = blank(); tbl[5].mem_v = 1; tbl[5].mem_epc = 64'h2000; tbl[5].mem_cause = 2; tbl[5].mem_tval = 64'hBAD0;
    tbl[5].id_v = 1; tbl[5].id_epc = 64'h2004; tbl[5].id_cause = 2; tbl[5].id_tval = 64'hBAD4;
    tbl[5].mret = 1; tbl[5].medeleg = 64'h4;
    tbl[5].nwr = 4; tbl[5].addr = {12'h300, 12'h143, 12'h142, 12'h141};
    tbl[5].data = {64'h100, 64'hBAD0, 64'h2, 64'h2000}; tbl[5].pc = 64'h9000; tbl[5].priv = 1;
    // mret MPP=1, MPIE=1
    tbl[6] = blank(); tbl[6].mret = 1; tbl[6].mstatus = 64'h880; tbl[6].mepc = 64'h3000;
    tbl[6].nwr = 1; tbl[6].addr[0] = 12'h300; tbl[6].data[0] = 64'h88; tbl[6].pc = 64'h3000; tbl[6].priv = 1;
    // S-mode cause not in medeleg goes to M (exception injected mid-trap)
    tbl[7] = blank(); tbl[7].mem_v = 1; tbl[7].mem_epc = 64'h4000; tbl[7].mem_cause = 5; tbl[7].mem_tval = 64'h44;
    tbl[7].medeleg = 64'h100; tbl[7].mstatus = 64'h2;
    tbl[7].nwr = 4; tbl[7].addr = {12'h300, 12'h343, 12'h342, 12'h341};
    tbl[7].data = {64'h802, 64'h44, 64'h5, 64'h4000}; tbl[7].pc = 64'h8000_0000; tbl[7].priv = 3;
    // M-mode trap ignores medeleg
    tbl[8] = blank(); tbl[8].id_v = 1; tbl[8].id_epc = 64'h5000; tbl[8].id_cause = 8;
    tbl[8].medeleg = '1; tbl[8].mstatus = 64'h8;
    tbl[8].nwr = 4; tbl[8].addr = {12'h300, 12'h343, 12'h342, 12'h341};
    tbl[8].data = {64'h1880, 64'h0, 64'h8, 64'h5000}; tbl[8].pc = 64'h8000_0000; tbl[8].priv = 3;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i == 7);

    // Reset in W_CAUSE abandons the trap.
    v = tbl[3];
    @(posedge clk); #1;
    drive(v);
    @(posedge clk); #1;
    clear_events();
    @(negedge clk);
    chk("abort_epc_we", 64'(csr_we_o), 64'd1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_we", 64'(csr_we_o), 64'd0);
    chk("abort_waddr", 64'(csr_waddr_o), 64'd0);
    chk("abort_wdata", csr_wdata_o, 64'd0);
    chk("abort_stall", 64'(stall_o), 64'd0);
    chk("abort_redir", 64'(redirect_valid_o), 64'd0);
    chk("abort_priv", 64'(priv_o), 64'd3);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_quiet_we", 64'(csr_we_o), 64'd0);
      chk("abort_quiet_stall", 64'(stall_o), 64'd0);
    end
    cur_priv = 2'd3;

    // Randomized events against the model.
    for (int i = 0; i < 40; i++) begin
      int kind;
      v = blank();
      kind = int'($urandom_range(0, 4));
      v.mem_v = (kind == 0 || kind == 2);
      v.id_v  = (kind == 1 || kind == 2);
      v.mret  = (kind == 3) || (kind < 3 && $urandom_range(0, 1) == 1);
      v.sret  = (kind == 4) || ($urandom_range(0, 1) == 1);
      v.mem_epc = {$urandom, $urandom}; v.mem_cause = 64'($urandom_range(0, 63));
      v.mem_tval = {$urandom, $urandom};
      v.id_epc = {$urandom, $urandom}; v.id_cause = 64'($urandom_range(0, 63));
      v.id_tval = {$urandom, $urandom};
      v.mstatus = {$urandom, $urandom}; v.medeleg = {$urandom, $urandom};
      v.mtvec = {$urandom, $urandom}; v.stvec = {$urandom, $urandom};
      v.mepc = {$urandom, $urandom}; v.sepc = {$urandom, $urandom};
      run_vec(model(v, cur_priv), (i % 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
